// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, R/W bit values,
// default field widths and the frame-length helper.
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic SPI_READ  = 1'b1;
  localparam logic SPI_WRITE = 1'b0;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  // Frame = address field, one R/W bit, data field.
  function automatic int frame_bits(input int addr_w, input int data_w);
    return addr_w + 1 + data_w;
  endfunction

  localparam int FRAME_BITS = frame_bits(ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/spi_master_clk_gen.sv
// Half-period tick generator for the SPI master. o_tick pulses on the last
// clk of every CLK_DIV-cycle window; i_restart realigns the window so the
// first tick lands exactly CLK_DIV cycles after the restart cycle.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int                CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running modulo-CLK_DIV counter, forced back to zero on restart.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/spi_master.sv
// SPI master (mode 0): turns one {addr, rw, wdata} command into a 16-bit
// MSB-first frame with a start/done handshake. Pins are registered from the
// next-state decode so they are glitch-free and return to idle values
// immediately on reset.
// Build option: define SPI_MISO_SYNC_EN to pass miso_pin through a 2-flop
// synchronizer (needs CLK_DIV >= 4); otherwise miso_pin is sampled directly.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  localparam int                W_FRAME         = frame_bits(ADDR_W, DATA_W);
  localparam int                N_HALVES        = 2 * W_FRAME;
  localparam int                HALF_W          = $clog2(N_HALVES);
  localparam logic [HALF_W-1:0] LAST_HALF       = HALF_W'(N_HALVES - 1);
  localparam logic [HALF_W-1:0] FIRST_DATA_HALF = HALF_W'(2 * (ADDR_W + 1));

  state_t              r_state, w_state_next;
  logic                w_tick, w_accept;
  logic                w_shift_tick, w_fall, w_sample, w_active_next;
  logic                w_sclk_next, w_miso;
  logic [W_FRAME-1:0]  r_shift, w_shift_next, w_frame;
  logic [HALF_W-1:0]   r_half;
  logic [DATA_W-1:0]   r_rx, r_rdata;
  logic                r_rw, r_sclk, r_cs, r_mosi;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_accept),
    .o_tick    (w_tick)
  );

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] r_miso_sync;

  // Two-flop synchronizer for the asynchronous slave data line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_miso_sync <= '0;
    else       r_miso_sync <= {r_miso_sync[0], miso_pin};
  end

  assign w_miso = r_miso_sync[1];
`else
  assign w_miso = miso_pin;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state, accept and handshake outputs.
  // NOTE: defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    done         = 1'b0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: if (w_tick) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && (r_half == LAST_HALF)) w_state_next = ST_HOLD;
      ST_HOLD:  if (w_tick) w_state_next = ST_GAP;
      ST_GAP: begin
        if (w_tick) begin
          done = 1'b1;
          busy = 1'b0;
          // A request in the done cycle starts the next frame right away.
          if (start) begin
            w_accept     = 1'b1;
            w_state_next = ST_SETUP;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Even half-periods in SHIFT are sclk-high; their closing tick is the
  // falling edge, where miso is sampled and mosi advances.
  assign w_shift_tick  = (r_state == ST_SHIFT) && w_tick;
  assign w_fall        = w_shift_tick && !r_half[0];
  assign w_sample      = w_fall && (r_half >= FIRST_DATA_HALF) && (r_rw == SPI_READ);
  assign w_frame       = {addr, rw, (rw == SPI_READ) ? {DATA_W{1'b0}} : wdata};
  assign w_active_next = (w_state_next == ST_SETUP) || (w_state_next == ST_SHIFT) ||
                         (w_state_next == ST_HOLD);

  // Next values for the shifter and sclk, derived from the next state.
  always_comb begin
    w_shift_next = r_shift;
    if (w_accept)    w_shift_next = w_frame;
    else if (w_fall) w_shift_next = r_shift << 1;
    w_sclk_next = 1'b0;
    if (w_state_next == ST_SHIFT) begin
      // Entering SHIFT is the first rising edge; afterwards toggle per tick.
      w_sclk_next = (r_state == ST_SHIFT) ? (r_sclk ^ w_tick) : 1'b1;
    end
  end

  // Datapath and registered pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_half  <= '0;
      r_rw    <= 1'b0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_sclk  <= w_sclk_next;
      r_cs    <= !w_active_next;
      r_mosi  <= ((w_state_next == ST_SETUP) || (w_state_next == ST_SHIFT)) &&
                 w_shift_next[W_FRAME-1];
      if (w_accept) begin
        r_rw   <= rw;
        r_half <= '0;
      end else if (w_shift_tick) begin
        r_half <= r_half + 1'b1;
      end
      if (w_sample) r_rx <= {r_rx[DATA_W-2:0], w_miso};
      // Read data becomes visible only once the frame has fully completed.
      if (done && (r_rw == SPI_READ)) r_rdata <= r_rx;
    end
  end

  assign sclk_pin = r_sclk;
  assign cs_pin   = r_cs;
  assign mosi_pin = r_mosi;
  assign rdata    = r_rdata;

endmodule
